// File: rtl/button_scan_ctrl.sv
// Push-button controller: 2-flop sync, per-button debounce FSM on a shared tick,
// sticky W1C press events with level interrupt, 4-register bus slave with registered read data.
module button_scan_ctrl #(
  parameter int N_BTN     = 4,
  parameter int TICK_DIV  = 1000,
  parameter int LIMIT_RST = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_BTN-1:0] btn_i,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [1:0]       addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o,
  output logic             irq_o,
  output logic [N_BTN-1:0] level_o
);

  localparam int              PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRE_MAX    = PW'(TICK_DIV - 1);
  localparam logic [15:0]     LIMIT_INIT = 16'(LIMIT_RST);

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_WAIT_PRESS   = 2'd1,
    S_PRESSED      = 2'd2,
    S_WAIT_RELEASE = 2'd3
  } state_t;

  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;
  logic [PW-1:0]    r_pre;
  logic             w_tick;

  state_t           r_state     [N_BTN];
  state_t           w_state_nxt [N_BTN];
  logic [15:0]      r_cnt       [N_BTN];
  logic [15:0]      w_cnt_nxt   [N_BTN];
  logic [N_BTN-1:0] w_level_nxt;
  logic [N_BTN-1:0] w_press;
  logic [N_BTN-1:0] r_level;

  logic [N_BTN-1:0] r_events;
  logic [N_BTN-1:0] r_irq_en;
  logic [15:0]      r_limit;
  logic [31:0]      r_rdata;
  logic [N_BTN-1:0] w_clr;
  logic [N_BTN-1:0] w_events_nxt;
  logic             w_wr_events;
  logic             w_wr_irq_en;
  logic             w_wr_limit;
  logic [31:0]      w_rd_mux;
  logic             w_unused_wdata;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_tick = (r_pre == PRE_MAX);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  // Counters reload in the settled states so a DB_LIMIT write only affects the next debounce.
  always_comb begin
    w_level_nxt = '0;
    w_press     = '0;
    for (int i = 0; i < N_BTN; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      case (r_state[i])
        S_IDLE: begin
          w_cnt_nxt[i] = r_limit;
          if (r_sync2[i]) begin
            w_state_nxt[i] = S_WAIT_PRESS;
          end
        end
        S_WAIT_PRESS: begin
          if (!r_sync2[i]) begin
            w_state_nxt[i] = S_IDLE;
            w_cnt_nxt[i]   = r_limit;
          end else if (w_tick) begin
            if (r_cnt[i] == 16'd0) begin
              w_state_nxt[i] = S_PRESSED;
              w_cnt_nxt[i]   = r_limit;
              w_press[i]     = 1'b1;
            end else begin
              w_cnt_nxt[i] = r_cnt[i] - 16'd1;
            end
          end
        end
        S_PRESSED: begin
          w_cnt_nxt[i] = r_limit;
          if (!r_sync2[i]) begin
            w_state_nxt[i] = S_WAIT_RELEASE;
          end
        end
        S_WAIT_RELEASE: begin
          if (r_sync2[i]) begin
            w_state_nxt[i] = S_PRESSED;
            w_cnt_nxt[i]   = r_limit;
          end else if (w_tick) begin
            if (r_cnt[i] == 16'd0) begin
              w_state_nxt[i] = S_IDLE;
              w_cnt_nxt[i]   = r_limit;
            end else begin
              w_cnt_nxt[i] = r_cnt[i] - 16'd1;
            end
          end
        end
        default: begin
          w_state_nxt[i] = S_IDLE;
          w_cnt_nxt[i]   = r_limit;
        end
      endcase
      w_level_nxt[i] = (w_state_nxt[i] == S_PRESSED) || (w_state_nxt[i] == S_WAIT_RELEASE);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < N_BTN; i++) begin
        r_state[i] <= S_IDLE;
        r_cnt[i]   <= LIMIT_INIT;
      end
      r_level <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
      r_level <= w_level_nxt;
    end
  end

  assign w_wr_events  = we_i && (addr_i == 2'd1);
  assign w_wr_irq_en  = we_i && (addr_i == 2'd2);
  assign w_wr_limit   = we_i && (addr_i == 2'd3);
  assign w_clr        = w_wr_events ? wdata_i[N_BTN-1:0] : '0;
  // A press landing in the same cycle as its clear must survive.
  assign w_events_nxt = (r_events & ~w_clr) | w_press;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_events <= '0;
      r_irq_en <= '0;
      r_limit  <= LIMIT_INIT;
    end else begin
      r_events <= w_events_nxt;
      if (w_wr_irq_en) begin
        r_irq_en <= wdata_i[N_BTN-1:0];
      end
      if (w_wr_limit) begin
        r_limit <= wdata_i[15:0];
      end
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (addr_i)
      2'd0:    w_rd_mux[N_BTN-1:0] = r_level;
      2'd1:    w_rd_mux[N_BTN-1:0] = r_events;
      2'd2:    w_rd_mux[N_BTN-1:0] = r_irq_en;
      default: w_rd_mux[15:0]      = r_limit;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rdata <= '0;
    end else if (re_i) begin
      r_rdata <= w_rd_mux;
    end
  end

  assign w_unused_wdata = ^wdata_i[31:16];

  assign rdata_o = r_rdata;
  assign level_o = r_level;
  assign irq_o   = |(r_events & r_irq_en);

endmodule
